// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite responder over a word-addressed memory; OKAY data phase = WAIT_STATES+1 cycles, ERROR = 2 cycles.
// Address phases are never stalled by this slave; acceptance follows the bus-wide hready only.
module ahb_lite_mem_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MEM_DEPTH   = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int          IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(4 * MEM_DEPTH);
    localparam logic [3:0]  WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic               resp_q, resp_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         lane_q, lane_d;
    logic [1:0]         size_q, size_d;
    logic               write_q, write_d;
    logic               err_q, err_d;

    logic [31:0]        mem_q [MEM_DEPTH];

    logic [32:0]        offset;
    logic               accept;
    logic               new_err;
    logic [3:0]         byte_en;
    logic               unused_inputs;

    // A haddr below BASE_ADDR borrows into bit 32, so one unsigned compare covers both range limits.
    assign offset  = {1'b0, haddr} - {1'b0, BASE_ADDR};
    assign accept  = hsel & hready & htrans[1];
    assign new_err = (offset >= MEM_BYTES)
                   | (hsize > 3'd2)
                   | ((hsize == 3'd1) & haddr[0])
                   | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));

    assign unused_inputs = ^{hburst, htrans[0]};

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        resp_d  = resp_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        size_d  = size_q;
        write_d = write_q;
        err_d   = err_q;
        unique case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
                ready_d = 1'b1;
                resp_d  = 1'b1;
            end
            default: begin
                // IDLE, DONE and ERR2 all end with hreadyout=1, so each may take a new address phase.
                state_d = S_IDLE;
                ready_d = 1'b1;
                resp_d  = 1'b0;
                if (accept) begin
                    idx_d   = offset[IDX_W+1:2];
                    lane_d  = haddr[1:0];
                    size_d  = hsize[1:0];
                    write_d = hwrite;
                    err_d   = new_err;
                    if (new_err) begin
                        state_d = S_ERR1;
                        ready_d = 1'b0;
                        resp_d  = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        ready_d = 1'b0;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            lane_q  <= 2'd0;
            size_q  <= 2'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            resp_q  <= resp_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            write_q <= write_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        byte_en = 4'b0000;
        if (state_q == S_DONE && write_q && !err_q) begin
            unique case (size_q)
                2'd0:    byte_en = 4'b0001 << lane_q;
                2'd1:    byte_en = 4'b0011 << lane_q;
                default: byte_en = 4'b1111;
            endcase
        end
    end

    // Lanes commit on the edge that ends DONE; reset forces IDLE, so an aborted write never lands.
    always_ff @(posedge hclk) begin
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    assign hreadyout = ready_q;
    assign hresp     = resp_q;
    assign hrdata    = (state_q == S_DONE && !write_q) ? mem_q[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: three instances (0, 3 and 5 wait states) driven one at a time
// by a pipelined AHB-Lite master and checked cycle by cycle against a transaction-level memory model.
module tb_ahb_lite_mem_slave;

    localparam int DEPTH = 1024;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        m_sel;
    logic [31:0] m_addr;
    logic [1:0]  m_trans;
    logic        m_write;
    logic [2:0]  m_size;
    logic [2:0]  m_burst;
    logic [31:0] m_wdata;
    int          act;

    logic [2:0]  ro_w;
    logic [2:0]  rsp_w;
    logic [31:0] rd_w [3];

    always #5 hclk = ~hclk;

    ahb_lite_mem_slave #(.BASE_ADDR(32'h0), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(m_sel && act == 0), .haddr(m_addr),
        .htrans(m_trans), .hwrite(m_write), .hsize(m_size), .hburst(m_burst),
        .hwdata(m_wdata), .hready(ro_w[0]), .hreadyout(ro_w[0]), .hresp(rsp_w[0]),
        .hrdata(rd_w[0]));

    ahb_lite_mem_slave #(.BASE_ADDR(32'h0), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u1 (
        .hclk(hclk), .hresetn(hresetn), .hsel(m_sel && act == 1), .haddr(m_addr),
        .htrans(m_trans), .hwrite(m_write), .hsize(m_size), .hburst(m_burst),
        .hwdata(m_wdata), .hready(ro_w[1]), .hreadyout(ro_w[1]), .hresp(rsp_w[1]),
        .hrdata(rd_w[1]));

    ahb_lite_mem_slave #(.BASE_ADDR(32'h0), .MEM_DEPTH(DEPTH), .WAIT_STATES(5)) u2 (
        .hclk(hclk), .hresetn(hresetn), .hsel(m_sel && act == 2), .haddr(m_addr),
        .htrans(m_trans), .hwrite(m_write), .hsize(m_size), .hburst(m_burst),
        .hwdata(m_wdata), .hready(ro_w[2]), .hreadyout(ro_w[2]), .hresp(rsp_w[2]),
        .hrdata(rd_w[2]));

    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit        wr;
        bit [2:0]  size;
        bit [31:0] addr;
        bit [31:0] data;
    } beat_t;

    beat_t       bq[$];
    logic [31:0] mdl [3][DEPTH];
    logic [31:0] last_rd;
    int          total = 0;
    int          bad   = 0;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 3 : 5;
    endfunction

    function automatic bit beat_err(input beat_t b);
        return (b.addr >= 32'(4 * DEPTH)) || (b.size > 3'd2) ||
               (b.size == 3'd1 && b.addr[0]) || (b.size == 3'd2 && b.addr[1:0] != 2'b00);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input bit sel, input bit [1:0] tr, input bit wr, input bit [2:0] sz,
                        input bit [31:0] a, input bit [31:0] d);
        beat_t b;
        b.sel = sel; b.trans = tr; b.wr = wr; b.size = sz; b.addr = a; b.data = d;
        bq.push_back(b);
    endtask

    // Byte i of the word is written when it lies inside [addr[1:0], addr[1:0] + 2**size).
    task automatic model_write(input int k, input beat_t b, input logic [31:0] wd);
        int lo, nb;
        logic [31:0] w;
        lo = int'(b.addr[1:0]);
        nb = 1 << b.size;
        w  = mdl[k][b.addr[11:2]];
        for (int i = 0; i < 4; i++)
            if (i >= lo && i < lo + nb) w[8*i +: 8] = wd[8*i +: 8];
        mdl[k][b.addr[11:2]] = w;
    endtask

    task automatic drive_idle();
        m_sel = 1'b0; m_trans = 2'd0; m_addr = 32'h0; m_write = 1'b0; m_size = 3'd0;
    endtask

    task automatic run_seq(input int k);
        int cur, dp, ph, n, ws;
        bit rdy, exp_ro, exp_rsp;
        logic [31:0] exp_rd;
        ws = ws_of(k);
        n  = bq.size();
        cur = 0; dp = -1; ph = 0;
        @(posedge hclk); #1;
        act = k;
        while (cur < n || dp >= 0) begin
            if (cur < n) begin
                m_sel = bq[cur].sel; m_trans = bq[cur].trans; m_write = bq[cur].wr;
                m_size = bq[cur].size; m_addr = bq[cur].addr;
            end else begin
                drive_idle();
            end
            m_wdata = (dp >= 0) ? bq[dp].data : $urandom;
            @(negedge hclk);
            if (dp < 0) begin
                exp_ro = 1'b1; exp_rsp = 1'b0; exp_rd = 32'h0;
            end else if (beat_err(bq[dp])) begin
                exp_ro = (ph >= 1); exp_rsp = 1'b1; exp_rd = 32'h0;
            end else begin
                exp_ro = (ph >= ws); exp_rsp = 1'b0;
                exp_rd = (ph >= ws && !bq[dp].wr) ? mdl[k][bq[dp].addr[11:2]] : 32'h0;
            end
            chk($sformatf("hreadyout[%0d]", k), {31'b0, ro_w[k]}, {31'b0, exp_ro});
            chk($sformatf("hresp[%0d]", k), {31'b0, rsp_w[k]}, {31'b0, exp_rsp});
            chk($sformatf("hrdata[%0d]", k), rd_w[k], exp_rd);
            if (dp >= 0 && exp_ro && !exp_rsp && !bq[dp].wr) last_rd = rd_w[k];
            rdy = ro_w[k];
            @(posedge hclk);
            if (rdy) begin
                if (dp >= 0 && bq[dp].wr && !beat_err(bq[dp])) model_write(k, bq[dp], bq[dp].data);
                dp = (cur < n && bq[cur].sel && bq[cur].trans[1]) ? cur : -1;
                if (cur < n) cur++;
                ph = 0;
            end else begin
                ph++;
                if (ph > 20) begin
                    total++; bad++;
                    $error("FAIL timeout[%0d] observed=stalled expected=hreadyout within 20 cycles", k);
                    dp = -1; cur = n;
                end
            end
            #1;
        end
        drive_idle();
        bq.delete();
    endtask

    initial begin
        hresetn = 1'b0; act = 0; m_burst = 3'd0; m_wdata = 32'h0; last_rd = 32'h0;
        drive_idle();

        // Reset: three cycles low, then check every instance.
        repeat (3) @(posedge hclk);
        @(negedge hclk); hresetn = 1'b1;
        @(negedge hclk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready[%0d]", k), {31'b0, ro_w[k]}, 32'h1);
            chk($sformatf("rst_resp[%0d]", k), {31'b0, rsp_w[k]}, 32'h0);
            chk($sformatf("rst_rdata[%0d]", k), rd_w[k], 32'h0);
        end

        // Single write then read.
        push(1, 2'd2, 1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        push(1, 2'd2, 0, 3'd2, 32'h10, 32'h0);
        run_seq(0);
        chk("wr_rd_word", last_rd, 32'hDEAD_BEEF);

        // Byte and halfword lanes.
        push(1, 2'd2, 1, 3'd2, 32'h20, 32'h0);
        push(1, 2'd2, 1, 3'd0, 32'h21, 32'h0000_AA00);
        push(1, 2'd2, 1, 3'd1, 32'h22, 32'h1234_0000);
        push(1, 2'd2, 0, 3'd2, 32'h20, 32'h0);
        run_seq(0);
        chk("byte_half_lanes", last_rd, 32'h1234_AA00);

        // Pipelined NONSEQ/SEQ writes, IDLE, read back.
        push(1, 2'd2, 1, 3'd2, 32'h0, 32'hA5A5_0001);
        push(1, 2'd3, 1, 3'd2, 32'h4, 32'h5A5A_0002);
        push(1, 2'd0, 0, 3'd2, 32'h0, 32'h0);
        push(1, 2'd2, 0, 3'd2, 32'h4, 32'h0);
        run_seq(0);
        chk("pipe_seq_data", last_rd, 32'h5A5A_0002);

        // BUSY and deselected beats must not write.
        push(1, 2'd1, 1, 3'd2, 32'h4, 32'hFFFF_FFFF);
        push(0, 2'd2, 1, 3'd2, 32'h4, 32'hFFFF_FFFF);
        push(1, 2'd2, 0, 3'd2, 32'h4, 32'h0);
        run_seq(0);
        chk("busy_nosel_nochange", last_rd, 32'h5A5A_0002);

        // ERROR responses: out of range, misaligned, oversize.
        push(1, 2'd2, 1, 3'd2, 32'h1000, 32'h1111_1111);
        push(1, 2'd2, 1, 3'd2, 32'h2, 32'h2222_2222);
        push(1, 2'd2, 1, 3'd3, 32'h0, 32'h3333_3333);
        push(1, 2'd2, 0, 3'd2, 32'h0, 32'h0);
        run_seq(0);
        chk("err_no_write", last_rd, 32'hA5A5_0001);

        // Three wait states, back-to-back reads.
        push(1, 2'd2, 1, 3'd2, 32'h10, 32'hCAFE_0010);
        push(1, 2'd2, 1, 3'd2, 32'h14, 32'hCAFE_0014);
        push(1, 2'd2, 0, 3'd2, 32'h10, 32'h0);
        push(1, 2'd2, 0, 3'd2, 32'h14, 32'h0);
        run_seq(1);
        chk("ws3_last_read", last_rd, 32'hCAFE_0014);

        // Reset during the wait phase of a write.
        push(1, 2'd2, 1, 3'd2, 32'h8, 32'h5555_AAAA);
        run_seq(2);
        @(posedge hclk); #1;
        act = 2; m_sel = 1'b1; m_trans = 2'd2; m_write = 1'b1; m_size = 3'd2; m_addr = 32'h8;
        @(posedge hclk); #1;
        drive_idle(); m_wdata = 32'h1111_2222;
        @(posedge hclk); #1;
        chk("mid_wait_ready", {31'b0, ro_w[2]}, 32'h0);
        @(posedge hclk); #1;
        hresetn = 1'b0;
        #1;
        chk("async_rst_ready", {31'b0, ro_w[2]}, 32'h1);
        chk("async_rst_resp", {31'b0, rsp_w[2]}, 32'h0);
        chk("async_rst_rdata", rd_w[2], 32'h0);
        repeat (2) @(posedge hclk);
        #1; hresetn = 1'b1;
        push(1, 2'd2, 0, 3'd2, 32'h8, 32'h0);
        run_seq(2);
        chk("rst_abort_keep", last_rd, 32'h5555_AAAA);

        // Randomized traffic against the model on every instance.
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 64; w++) push(1, 2'd2, 1, 3'd2, 32'(w * 4), $urandom);
            run_seq(k);
            for (int i = 0; i < 150; i++) begin
                beat_t b;
                int r;
                b.sel = ($urandom_range(0, 7) != 0);
                r = $urandom_range(0, 9);
                b.trans = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : 2'($urandom_range(2, 3));
                b.wr = 1'($urandom_range(0, 1));
                b.size = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                b.addr = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'($urandom_range(0, 255))
                                                     : 32'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) b.addr[1:0] = (b.size == 3'd1) ? {b.addr[1], 1'b0} : 2'b00;
                b.data = $urandom;
                bq.push_back(b);
            end
            run_seq(k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
